// File: rtl/write_port_buffer.sv
// write_port_buffer: write-side companion to the register-file read port.
// Buffers (index, data) write requests in a small FIFO and drains one per cycle
// onto a registered one-hot write-enable bus for the 32x32 register array.
// Register 0 is hardwired zero, so writes to it handshake but are discarded.
// Optional feature: define WRITE_PORT_BYPASS_EN to enable the combinational
// bypass search of pending entries (otherwise byp_hit/byp_data are tied 0).
module write_port_buffer #(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 32,
    parameter int NREG   = 32
) (
    input  logic              clock,
    input  logic              ctrl_reset,
    input  logic              ctrl_writeEnable,
    input  logic [4:0]        ctrl_writeReg,
    input  logic [DATA_W-1:0] data_writeReg,
    output logic              wr_ready,
    input  logic              drain_stall,
    output logic [NREG-1:0]   reg_we,
    output logic [DATA_W-1:0] reg_wdata,
    output logic              pending,
    output logic              overflow,
    input  logic [4:0]        ctrl_readReg,
    output logic              byp_hit,
    output logic [DATA_W-1:0] byp_data
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // FIFO storage; contents need no reset because validity comes from count
    logic [4:0]        idx_mem  [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0]  rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0]  count_reg, count_next;
    logic              overflow_reg, overflow_next;
    logic [NREG-1:0]   reg_we_reg;
    logic [DATA_W-1:0] reg_wdata_reg;

    logic              full;
    logic              push;
    logic              pop;
    logic [4:0]        head_idx;
    logic [DATA_W-1:0] head_data;
    logic [NREG-1:0]   we_decode;

    // Ready is based on current occupancy only: a same-cycle pop does not
    // make room for a push while full.
    assign full      = (count_reg == CNT_W'(DEPTH));
    assign wr_ready  = !full;
    assign pending   = (count_reg != '0);
    assign push      = ctrl_writeEnable && !full && (ctrl_writeReg != 5'd0);
    assign pop       = pending && !drain_stall;
    assign head_idx  = idx_mem[rd_ptr_reg];
    assign head_data = data_mem[rd_ptr_reg];

    assign reg_we    = reg_we_reg;
    assign reg_wdata = reg_wdata_reg;
    assign overflow  = overflow_reg;

    // One-hot decode of the head index; bit 0 can never fire
    assign we_decode[0] = 1'b0;
    generate
        for (genvar gi = 1; gi < NREG; gi++) begin : g_decode
            assign we_decode[gi] = (head_idx == 5'(gi));
        end
    endgenerate

    // Next-state for pointers, occupancy and the sticky overflow flag
    always_comb begin
        wr_ptr_next   = wr_ptr_reg;
        rd_ptr_next   = rd_ptr_reg;
        count_next    = count_reg;
        overflow_next = overflow_reg | (ctrl_writeEnable & full);
        if (push) begin
            wr_ptr_next = wr_ptr_reg + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_next = rd_ptr_reg + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase
    end

    // FIFO storage write on accepted non-zero-index requests
    always_ff @(posedge clock) begin
        if (push) begin
            idx_mem[wr_ptr_reg]  <= ctrl_writeReg;
            data_mem[wr_ptr_reg] <= data_writeReg;
        end
    end

    // Control state and registered write port; reset kills any in-flight write
    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
            reg_we_reg    <= '0;
            reg_wdata_reg <= '0;
        end else begin
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            count_reg    <= count_next;
            overflow_reg <= overflow_next;
            if (pop) begin
                reg_we_reg    <= we_decode;
                reg_wdata_reg <= head_data;
            end else begin
                reg_we_reg    <= '0;
            end
        end
    end

`ifdef WRITE_PORT_BYPASS_EN
    logic [PTR_W-1:0] byp_slot;

    // Scan oldest to youngest so the youngest matching entry wins
    always_comb begin
        byp_hit  = 1'b0;
        byp_data = '0;
        byp_slot = '0;
        for (int i = 0; i < DEPTH; i++) begin
            byp_slot = rd_ptr_reg + PTR_W'(i);
            if ((CNT_W'(i) < count_reg) && (ctrl_readReg != 5'd0) &&
                (idx_mem[byp_slot] == ctrl_readReg)) begin
                byp_hit  = 1'b1;
                byp_data = data_mem[byp_slot];
            end
        end
    end
`else
    logic unused_read_reg;

    assign unused_read_reg = ^ctrl_readReg;
    assign byp_hit         = 1'b0;
    assign byp_data        = '0;
`endif

endmodule

// File: tb/tb_write_port_buffer.sv
// tb_write_port_buffer: directed plus randomized checks of write_port_buffer
// against a queue-based reference model of the pending write list.
module tb_write_port_buffer;

    localparam int DEPTH  = 2;
    localparam int DATA_W = 32;
    localparam int NREG   = 32;

    logic              clock = 1'b0;
    logic              ctrl_reset;
    logic              ctrl_writeEnable;
    logic [4:0]        ctrl_writeReg;
    logic [DATA_W-1:0] data_writeReg;
    logic              wr_ready;
    logic              drain_stall;
    logic [NREG-1:0]   reg_we;
    logic [DATA_W-1:0] reg_wdata;
    logic              pending;
    logic              overflow;
    logic [4:0]        ctrl_readReg;
    logic              byp_hit;
    logic [DATA_W-1:0] byp_data;

    always #5 clock = ~clock;

    write_port_buffer #(.DEPTH(DEPTH), .DATA_W(DATA_W), .NREG(NREG)) dut (
        .clock            (clock),
        .ctrl_reset       (ctrl_reset),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .data_writeReg    (data_writeReg),
        .wr_ready         (wr_ready),
        .drain_stall      (drain_stall),
        .reg_we           (reg_we),
        .reg_wdata        (reg_wdata),
        .pending          (pending),
        .overflow         (overflow),
        .ctrl_readReg     (ctrl_readReg),
        .byp_hit          (byp_hit),
        .byp_data         (byp_data)
    );

    typedef struct {
        logic [4:0]        idx;
        logic [DATA_W-1:0] data;
    } entry_t;

    // Reference model: ordered list of pending writes plus output expectations
    entry_t            model_q[$];
    logic              model_overflow = 1'b0;
    logic [NREG-1:0]   model_we       = '0;
    logic [DATA_W-1:0] model_wdata    = '0;

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Youngest pending entry with a matching index; index 0 never matches
    task automatic model_bypass(input logic [4:0] rd, output logic hit, output logic [DATA_W-1:0] d);
        hit = 1'b0;
        d   = '0;
        if (rd != 5'd0) begin
            for (int i = model_q.size() - 1; i >= 0; i--) begin
                if (model_q[i].idx == rd) begin
                    hit = 1'b1;
                    d   = model_q[i].data;
                    break;
                end
            end
        end
    endtask

    // One clock cycle: drive inputs, check combinational outputs, advance the
    // model, then check registered outputs just after the edge.
    task automatic step(input string tag, input logic we, input logic [4:0] idx,
                        input logic [DATA_W-1:0] data, input logic stall, input logic [4:0] rd);
        logic              exp_hit;
        logic [DATA_W-1:0] exp_bd;
        int                sz;
        entry_t            e;
        ctrl_writeEnable = we;
        ctrl_writeReg    = idx;
        data_writeReg    = data;
        drain_stall      = stall;
        ctrl_readReg     = rd;
        #1;
        sz = model_q.size();
        check({tag, ".wr_ready"}, 64'(wr_ready), 64'(sz < DEPTH));
        check({tag, ".pending_pre"}, 64'(pending), 64'(sz != 0));
`ifdef WRITE_PORT_BYPASS_EN
        model_bypass(rd, exp_hit, exp_bd);
`else
        exp_hit = 1'b0;
        exp_bd  = '0;
`endif
        check({tag, ".byp_hit"}, 64'(byp_hit), 64'(exp_hit));
        check({tag, ".byp_data"}, 64'(byp_data), 64'(exp_bd));
        if (sz != 0 && !stall) begin
            model_we    = NREG'(1) << model_q[0].idx;
            model_wdata = model_q[0].data;
            void'(model_q.pop_front());
        end else begin
            model_we = '0;
        end
        if (we && sz >= DEPTH) begin
            model_overflow = 1'b1;
        end else if (we && idx != 5'd0) begin
            e.idx  = idx;
            e.data = data;
            model_q.push_back(e);
        end
        @(posedge clock);
        #1;
        check({tag, ".reg_we"}, 64'(reg_we), 64'(model_we));
        check({tag, ".reg_wdata"}, 64'(reg_wdata), 64'(model_wdata));
        check({tag, ".overflow"}, 64'(overflow), 64'(model_overflow));
        check({tag, ".pending"}, 64'(pending), 64'(model_q.size() != 0));
        $display("[TB] %s we=%0b idx=%0d data=%h stall=%0b rd=%0d -> reg_we=%h wdata=%h pend=%0b ovf=%0b byp=%0b/%h",
                 tag, we, idx, data, stall, rd, reg_we, reg_wdata, pending, overflow, byp_hit, byp_data);
    endtask

    // Asynchronous reset pulse in the middle of a cycle
    task automatic mid_reset(input string tag);
        #1;
        ctrl_reset = 1'b1;
        #1;
        check({tag, ".reg_we"}, 64'(reg_we), 64'd0);
        check({tag, ".reg_wdata"}, 64'(reg_wdata), 64'd0);
        check({tag, ".pending"}, 64'(pending), 64'd0);
        check({tag, ".overflow"}, 64'(overflow), 64'd0);
        check({tag, ".wr_ready"}, 64'(wr_ready), 64'd1);
        check({tag, ".byp_hit"}, 64'(byp_hit), 64'd0);
        model_q.delete();
        model_we       = '0;
        model_wdata    = '0;
        model_overflow = 1'b0;
        #1;
        ctrl_reset = 1'b0;
        $display("[TB] %s reset pulse -> reg_we=%h pend=%0b ovf=%0b rdy=%0b", tag, reg_we, pending, overflow, wr_ready);
    endtask

    initial begin
        ctrl_reset       = 1'b1;
        ctrl_writeEnable = 1'b0;
        ctrl_writeReg    = '0;
        data_writeReg    = '0;
        drain_stall      = 1'b0;
        ctrl_readReg     = '0;
        #12;
        check("rst.reg_we", 64'(reg_we), 64'd0);
        check("rst.reg_wdata", 64'(reg_wdata), 64'd0);
        check("rst.pending", 64'(pending), 64'd0);
        check("rst.overflow", 64'(overflow), 64'd0);
        check("rst.wr_ready", 64'(wr_ready), 64'd1);
        check("rst.byp_hit", 64'(byp_hit), 64'd0);
        check("rst.byp_data", 64'(byp_data), 64'd0);
        ctrl_reset = 1'b0;
        @(posedge clock);
        #1;

        // Single write, one cycle of staging then one-hot enable
        step("w5", 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0);
        check("w5.no_we_yet", 64'(reg_we), 64'd0);
        step("w5_drain", 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        check("w5.we_onehot", 64'(reg_we), 64'h20);
        check("w5.wdata", 64'(reg_wdata), 64'hDEADBEEF);
        step("w5_idle", 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);

        // Write to register 0 is accepted but discarded
        step("w0", 1'b1, 5'd0, 32'h12345678, 1'b0, 5'd0);
        step("w0_idle", 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        check("w0.pending", 64'(pending), 64'd0);

        // Fill while stalled, overflow on third write, then drain in order
        step("s3", 1'b1, 5'd3, 32'hA, 1'b1, 5'd0);
        step("s4", 1'b1, 5'd4, 32'hB, 1'b1, 5'd0);
        check("s4.wr_ready_low", 64'(wr_ready), 64'd0);
        step("s7_ovf", 1'b1, 5'd7, 32'hC, 1'b1, 5'd0);
        check("s7.overflow", 64'(overflow), 64'd1);
        step("drain_a", 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        check("drain_a.we", 64'(reg_we), 64'h8);
        step("drain_b", 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        check("drain_b.we", 64'(reg_we), 64'h10);
        step("drain_idle", 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);

        // Bypass lookup against two pending writes to the same register
        step("b9a", 1'b1, 5'd9, 32'h1, 1'b1, 5'd9);
        step("b9b", 1'b1, 5'd9, 32'h2, 1'b1, 5'd9);
        step("b_rd9", 1'b0, 5'd0, 32'h0, 1'b1, 5'd9);
        step("b_rd10", 1'b0, 5'd0, 32'h0, 1'b1, 5'd10);
        step("b_rd0", 1'b0, 5'd0, 32'h0, 1'b1, 5'd0);
        step("b_drain1", 1'b0, 5'd0, 32'h0, 1'b0, 5'd9);
        step("b_drain2", 1'b0, 5'd0, 32'h0, 1'b0, 5'd9);

        // Reset while a write is on the bus and another is pending
        step("r_fill1", 1'b1, 5'd12, 32'h11, 1'b1, 5'd0);
        step("r_fill2", 1'b1, 5'd13, 32'h22, 1'b1, 5'd0);
        step("r_ovf", 1'b1, 5'd14, 32'h33, 1'b1, 5'd0);
        step("r_pop", 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        mid_reset("mid_rst");
        for (int i = 0; i < 3; i++) begin
            step("post_rst", 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        end

        // Back-to-back stream, indices 1..10
        for (int i = 1; i <= 10; i++) begin
            step("b2b", 1'b1, 5'(i), 32'(i * 32'h1111), 1'b0, 5'(i));
        end
        step("b2b_tail1", 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        step("b2b_tail2", 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);

        // Randomized traffic with random stalls and lookups
        for (int n = 0; n < 400; n++) begin
            step("rnd", ($urandom_range(0, 2) != 0), 5'($urandom_range(0, 11)), $urandom,
                 ($urandom_range(0, 3) == 0), 5'($urandom_range(0, 11)));
            if (n == 200) begin
                mid_reset("rnd_rst");
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
